// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

    // Control FSM states; 15 of the 16 4-bit codes are used.
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_JALR1,
        S_JALR2,
        S_BRANCH,
        S_LUI,
        S_ILLEGAL
    } state_t;

    // What the ALU decoder should do for a given state.
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_R,
        ALU_CLS_I,
        ALU_CLS_BR
    } alu_class_t;

    // Opcodes (IR[6:0]).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALUControl codes; 3'b111 is reserved and never driven.
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    // Immediate formats.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Result mux.
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // ALU operand A mux.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU operand B mux.
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // State-decoded control word (everything except ALUControl/ImmSrc).
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_update;
        logic       branch;
        logic       halted;
    } ctrl_t;

    // Moore decode of the control word; anything not set stays 0.
    function automatic ctrl_t ctrl_for_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURES;
                c.pc_update  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_JAL, S_JALR2: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            S_JALR1: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_LUI: begin
                c.result_src = RES_IMM;
                c.reg_write  = 1'b1;
            end
            S_ILLEGAL: begin
                c.halted = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Which ALU decode a state needs; everything else is a plain ADD.
    function automatic alu_class_t alu_class_of(input state_t s);
        alu_class_t k;
        case (s)
            S_EXECR:  k = ALU_CLS_R;
            S_EXECI:  k = ALU_CLS_I;
            S_BRANCH: k = ALU_CLS_BR;
            default:  k = ALU_CLS_ADD;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation select and funct-field legality check for the control FSM.
// Latency: purely combinational.
// Backpressure: none.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [6:0]  op,
    output logic [2:0]  alu_control,
    output logic        funct_ok
);

    // Map funct3 (and funct7[5] for R-type) onto an ALU operation.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_class)
            ALU_CLS_R, ALU_CLS_I: begin
                case (funct3)
                    3'b000:  alu_control = (alu_class == ALU_CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    default: alu_control = ALU_ADD;
                endcase
            end
            ALU_CLS_BR: begin
                // beq/bne compare by subtraction; signed/unsigned less-than otherwise.
                case (funct3[2:1])
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: alu_control = ALU_SUB;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    // Legality of funct3/funct7[5] for the opcode; unknown opcodes are illegal.
    always_comb begin
        funct_ok = 1'b0;
        case (op)
            OP_LOAD, OP_STORE: funct_ok = (funct3 == 3'b010);
            OP_R:              funct_ok = (funct3 != 3'b001) && (funct3 != 3'b101) &&
                                          (!funct7_5 || funct3 == 3'b000);
            OP_I:              funct_ok = (funct3 != 3'b001) && (funct3 != 3'b101);
            OP_BRANCH:         funct_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
            OP_JALR:           funct_ok = (funct3 == 3'b000);
            OP_JAL, OP_LUI:    funct_ok = 1'b1;
            default:           funct_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RISC-V datapath, with illegal-op trap and instret.
// Latency: outputs registered from next state; lw 5, sw/R/I/jal 4, jalr 5, branch/lui 3 cycles.
// Backpressure: none; the FSM advances every cycle (ILLEGAL may park until reset).
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [2:0]       ImmSrc,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             funct_ok;
    logic             instr_legal;
    logic             taken;
    logic             retire;

    // ALU decode is computed for the state being entered so ALUControl can be registered.
    alu_decoder u_alu_decoder (
        .alu_class   (alu_class_of(state_d)),
        .funct3      (funct3),
        .funct7_5    (funct7[5]),
        .op          (op),
        .alu_control (alu_ctrl_d),
        .funct_ok    (funct_ok)
    );

    // Bits of funct7 other than [5] must be zero for R-type; other formats ignore funct7.
    assign instr_legal = funct_ok &&
                         ((op != OP_R) || (funct7[6] == 1'b0 && funct7[4:0] == 5'b00000));

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!instr_legal) begin
                    state_d = S_ILLEGAL;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXECR;
                        OP_I:              state_d = S_EXECI;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR1;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_LUI:            state_d = S_LUI;
                        default:           state_d = S_ILLEGAL;
                    endcase
                end
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR1:    state_d = S_JALR2;
            S_JALR2:    state_d = S_ALUWB;
            S_BRANCH:   state_d = S_FETCH;
            S_LUI:      state_d = S_FETCH;
            S_ILLEGAL:  state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control word for the upcoming state, plus retire counting on each instruction's last cycle.
    always_comb begin
        ctrl_d    = ctrl_for_state(state_d);
        retire    = state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_LUI};
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    // State, registered outputs and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            ctrl_q     <= ctrl_for_state(S_FETCH);
            alu_ctrl_q <= ALU_ADD;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            alu_ctrl_q <= alu_ctrl_d;
            instret_q  <= instret_d;
        end
    end

    // Branch resolution: beq/bne look at Zero directly, slt-based compares at its inverse.
    always_comb begin
        if (funct3[2]) begin
            taken = (~Zero) ^ funct3[0];
        end else begin
            taken = Zero ^ funct3[0];
        end
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            OP_LUI:    ImmSrc = IMM_U;
            default:   ImmSrc = IMM_I;
        endcase
    end

    assign PCWrite    = ctrl_q.pc_update | (ctrl_q.branch & taken);
    assign AdrSrc     = ctrl_q.adr_src;
    assign MemWrite   = ctrl_q.mem_write;
    assign IRWrite    = ctrl_q.ir_write;
    assign RegWrite   = ctrl_q.reg_write;
    assign ResultSrc  = ctrl_q.result_src;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign ALUControl = alu_ctrl_q;
    assign halted     = ctrl_q.halted;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks lw, sub, bne, blt, jalr and an illegal op.
// Latency: checks at the falling edge after each rising edge.
// Backpressure: none.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        Zero;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halted;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ALUControl, ImmSrc;
    logic [31:0] instret;

    int n_asserts = 0;
    int n_fail    = 0;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, halted}
    logic [14:0] ctl;
    assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, halted};

    localparam logic [14:0] V_FETCH     = 15'b1_0_0_1_0_10_00_10_000_0;
    localparam logic [14:0] V_DECODE    = 15'b0_0_0_0_0_00_01_01_000_0;
    localparam logic [14:0] V_MEMADR    = 15'b0_0_0_0_0_00_10_01_000_0;
    localparam logic [14:0] V_MEMREAD   = 15'b0_1_0_0_0_00_00_00_000_0;
    localparam logic [14:0] V_MEMWB     = 15'b0_0_0_0_1_01_00_00_000_0;
    localparam logic [14:0] V_EXECR_SUB = 15'b0_0_0_0_0_00_10_00_001_0;
    localparam logic [14:0] V_ALUWB     = 15'b0_0_0_0_1_00_00_00_000_0;
    localparam logic [14:0] V_BNE_T     = 15'b1_0_0_0_0_00_10_00_001_0;
    localparam logic [14:0] V_BNE_NT    = 15'b0_0_0_0_0_00_10_00_001_0;
    localparam logic [14:0] V_BLT_T     = 15'b1_0_0_0_0_00_10_00_101_0;
    localparam logic [14:0] V_JALR1     = 15'b0_0_0_0_0_00_10_01_000_0;
    localparam logic [14:0] V_JALR2     = 15'b1_0_0_0_0_00_01_10_000_0;
    localparam logic [14:0] V_ILLEGAL   = 15'b0_0_0_0_0_00_00_00_000_1;

    multicycle_controller #(
        .CNT_W           (32),
        .HALT_ON_ILLEGAL (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .halted     (halted),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // One clock: rising edge updates the DUT, falling edge is the sample point.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        op     = 7'b0000000;
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        Zero   = 1'b0;

        // Reset held for two cycles.
        step();
        step();
        chk("reset_ctl", 32'(ctl), 32'(V_FETCH));
        chk("reset_instret", instret, 32'd0);

        // lw: FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
        reset  = 1'b0;
        op     = 7'b0000011;
        funct3 = 3'b010;
        step();
        chk("lw_decode", 32'(ctl), 32'(V_DECODE));
        chk("lw_immsrc", 32'(ImmSrc), 32'(3'b000));
        step();
        chk("lw_memadr", 32'(ctl), 32'(V_MEMADR));
        step();
        chk("lw_memread", 32'(ctl), 32'(V_MEMREAD));
        step();
        chk("lw_memwb", 32'(ctl), 32'(V_MEMWB));
        chk("lw_instret_before", instret, 32'd0);
        step();
        chk("lw_fetch", 32'(ctl), 32'(V_FETCH));
        chk("lw_instret_after", instret, 32'd1);

        // sub: FETCH, DECODE, EXECR, ALUWB.
        op     = 7'b0110011;
        funct3 = 3'b000;
        funct7 = 7'b0100000;
        step();
        chk("sub_decode", 32'(ctl), 32'(V_DECODE));
        step();
        chk("sub_execr", 32'(ctl), 32'(V_EXECR_SUB));
        step();
        chk("sub_aluwb", 32'(ctl), 32'(V_ALUWB));
        step();
        chk("sub_fetch", 32'(ctl), 32'(V_FETCH));
        chk("sub_instret", instret, 32'd2);

        // bne: taken when Zero is low, not taken when high.
        op     = 7'b1100011;
        funct3 = 3'b001;
        funct7 = 7'b0000000;
        Zero   = 1'b0;
        step();
        step();
        chk("bne_taken", 32'(ctl), 32'(V_BNE_T));
        chk("bne_immsrc", 32'(ImmSrc), 32'(3'b010));
        Zero = 1'b1;
        #1;
        chk("bne_not_taken", 32'(ctl), 32'(V_BNE_NT));
        step();
        Zero = 1'b0;
        chk("bne_fetch", 32'(ctl), 32'(V_FETCH));
        chk("bne_instret", instret, 32'd3);

        // blt with Zero low: SLT, taken.
        funct3 = 3'b100;
        step();
        step();
        chk("blt_taken", 32'(ctl), 32'(V_BLT_T));
        step();
        chk("blt_instret", instret, 32'd4);

        // jalr: DECODE, JALR1, JALR2, ALUWB, back to FETCH.
        op     = 7'b1100111;
        funct3 = 3'b000;
        step();
        chk("jalr_decode", 32'(ctl), 32'(V_DECODE));
        step();
        chk("jalr_1", 32'(ctl), 32'(V_JALR1));
        step();
        chk("jalr_2", 32'(ctl), 32'(V_JALR2));
        step();
        chk("jalr_aluwb", 32'(ctl), 32'(V_ALUWB));
        chk("jalr_instret_before", instret, 32'd4);
        step();
        chk("jalr_fetch", 32'(ctl), 32'(V_FETCH));
        chk("jalr_instret_after", instret, 32'd5);

        // Unknown opcode: parks in ILLEGAL, counter frozen.
        op = 7'b1111111;
        step();
        step();
        chk("illegal_enter", 32'(ctl), 32'(V_ILLEGAL));
        for (int i = 0; i < 10; i++) begin
            step();
            chk("illegal_hold", 32'(ctl), 32'(V_ILLEGAL));
            chk("illegal_instret", instret, 32'd5);
        end

        // Reset mid-halt returns to FETCH with a cleared counter.
        reset = 1'b1;
        step();
        chk("halt_reset_ctl", 32'(ctl), 32'(V_FETCH));
        chk("halt_reset_instret", instret, 32'd0);
        reset = 1'b0;
        op    = 7'b0110111;
        step();
        chk("post_reset_decode", 32'(ctl), 32'(V_DECODE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
